instr_mem_loader_p: RTL and testbench
=====================================

INSTR_MEM_LOADER_P -- requirements
Module: instr_mem_loader_p

Interface
REQ-001 Parameter DATA_W, default 12, instruction word width in bits; legal range 4..32.
REQ-002 Parameter DEPTH, default 8, number of words; legal range 2..256.
REQ-003 Parameter WRAP, default 0: 1 = write pointer wraps, 0 = loading stops when full.
REQ-004 Parameter ADDR_W, default $clog2(DEPTH), address width; not overridden by users.
REQ-005 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 load_req  in  1  debounced load button, level; each rising edge writes one word.
REQ-008 load_data  in  DATA_W  switch data written on a load edge.
REQ-009 restore_req  in  1  level; restores the default program and rewinds the pointer.
REQ-010 rd_addr  in  ADDR_W  fetch address from the processor.
REQ-011 rd_data  out  DATA_W  registered word at rd_addr.
REQ-012 wr_ptr  out  ADDR_W  address of the next load write.
REQ-013 full  out  1  all DEPTH words loaded since the last restore (WRAP=0 only).
REQ-014 busy  out  1  high while the default image is being restored.

Function
REQ-015 FSM states are RESTORE, IDLE and HOLD.
REQ-016 RESTORE writes default_word(i) to mem[i] for i = 0..DEPTH-1, one word per cycle, then goes to IDLE; busy=1 throughout RESTORE.
REQ-017 default_word(i) = low (i+1) bits set and top 3 bits set, clipped to DATA_W (DATA_W=12, i=0 gives 0xE01; i=7 gives 0xEFF).
REQ-018 Load edge = load_req high and the previous-cycle sample of load_req low; edges are ignored in RESTORE.
REQ-019 On a load edge in IDLE with full=0: mem[wr_ptr] <= load_data at that edge; wr_ptr increments; state goes to HOLD.
REQ-020 HOLD returns to IDLE on the first cycle load_req is sampled low; a held button writes exactly once.
REQ-021 WRAP=0: the write to DEPTH-1 sets full=1 and leaves wr_ptr at DEPTH-1; later edges are ignored until restore.
REQ-022 WRAP=1: wr_ptr wraps from DEPTH-1 to 0; full stays 0.
REQ-023 rd_data <= mem[rd_addr] every cycle, including during RESTORE; latency is 1 cycle.
REQ-024 When a read and a write hit the same address in the same cycle, the read returns the old word.
REQ-025 restore_req high in any state enters RESTORE next cycle, clears wr_ptr and full, and restarts from i=0; restore_req has priority over a simultaneous load edge.
REQ-026 restore_req held high keeps the block in RESTORE at i=0; the restore sequence completes DEPTH cycles after release.
REQ-027 Non-power-of-two DEPTH: the restore index and wr_ptr never exceed DEPTH-1; rd_addr >= DEPTH returns 0.

Reset
REQ-028 While reset_n=0: state=RESTORE, restore index=0, wr_ptr=0, full=0, busy=1, rd_data=0, load sample=1 (a button held through reset does not write).
REQ-029 Memory contents are not cleared by reset; the RESTORE sequence rewrites them after reset_n deasserts.

Structure
REQ-030 Package imem_pkg holds the state enum and the default_word(i, DATA_W) function.
REQ-031 Rising-edge detection sits in sub-module load_edge_detect (CLK, reset_n, in, rise); storage is a plain array in the top module.

Verification
REQ-032 Reset release, defaults → busy high for exactly 8 cycles; then reading addresses 0..7 returns 0xE01, 0xE03, ... 0xEFF.
REQ-033 Load 0x123 then 0x456 with separate presses → mem[0]=0x123, mem[1]=0x456, wr_ptr=2; a press held for 20 cycles writes once.
REQ-034 WRAP=0, 9 presses → full=1 after the 8th press; the 9th press is ignored and mem[7] keeps the 8th value.
REQ-035 WRAP=1, DEPTH=5, 6 presses → wr_ptr sequence 1,2,3,4,0,1; the 6th value lands in mem[0]; full stays 0.
REQ-036 restore_req and a load edge in the same cycle at wr_ptr=3 → no write occurs; wr_ptr=0, full=0; after DEPTH cycles the default image is present.
REQ-037 Assert reset_n mid-RESTORE (i=4) with load_req held high → busy restarts and the restore runs from i=0; no load write occurs until load_req goes low and rises again.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and the default-program generator for the instruction memory loader.
package imem_pkg;

  typedef enum logic [1:0] {
    RESTORE,
    IDLE,
    HOLD
  } state_t;

  // Word i of the default program: low (i+1) bits plus the top three bits, clipped to data_w.
  function automatic logic [31:0] default_word(input int i, input int data_w);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < data_w && (b <= i || b >= data_w - 3)) begin
        w[b] = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/load_edge_detect.sv
// Rising-edge detector for the debounced load button.
module load_edge_detect (
  input  logic CLK,
  input  logic reset_n,
  input  logic in,
  output logic rise
);

  logic prev;

  // The sample resets high so that a button held through reset cannot produce a write.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b1;
    end else begin
      prev <= in;
    end
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/instr_mem_loader_p.sv
// Instruction memory loaded from switches one word per button press,
// with a restorable default program and a registered read port.
module instr_mem_loader_p
  import imem_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int WRAP   = 0,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              load_req,
  input  logic [DATA_W-1:0] load_data,
  input  logic              restore_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              full,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] rst_idx;
  logic              load_rise;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  load_edge_detect u_edge (
    .CLK     (CLK),
    .reset_n (reset_n),
    .in      (load_req),
    .rise    (load_rise)
  );

  // A pending restore request suppresses every write, including a coincident load edge.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!restore_req) begin
      if (state == RESTORE) begin
        mem_we    = 1'b1;
        mem_addr  = rst_idx;
        mem_wdata = DATA_W'(default_word(int'(rst_idx), DATA_W));
      end else if (state == IDLE && load_rise && !full) begin
        mem_we    = 1'b1;
        mem_addr  = wr_ptr;
        mem_wdata = load_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RESTORE;
      rst_idx <= '0;
      wr_ptr  <= '0;
      full    <= 1'b0;
      busy    <= 1'b1;
    end else if (restore_req) begin
      state   <= RESTORE;
      rst_idx <= '0;
      wr_ptr  <= '0;
      full    <= 1'b0;
      busy    <= 1'b1;
    end else begin
      case (state)
        RESTORE: begin
          if (rst_idx == LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            rst_idx <= '0;
          end else begin
            rst_idx <= rst_idx + 1'b1;
          end
        end
        IDLE: begin
          if (load_rise && !full) begin
            state <= HOLD;
            // Without wrap the pointer parks on the last word and full blocks further loads.
            if (wr_ptr == LAST) begin
              if (WRAP != 0) begin
                wr_ptr <= '0;
              end else begin
                full <= 1'b1;
              end
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        HOLD: begin
          if (!load_req) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= RESTORE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Read-before-write: the same-cycle write is not visible until the following read.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (int'(rd_addr) < DEPTH) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader_p.sv
// Directed bench: a default-parameter loader and a DEPTH=5 wrapping loader on a shared clock and reset.
module tb_instr_mem_loader_p;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset_n;
  logic        load_req0, restore_req0, full0, busy0;
  logic [11:0] load_data0, rd_data0;
  logic [2:0]  rd_addr0, wr_ptr0;
  logic        load_req1, restore_req1, full1, busy1;
  logic [11:0] load_data1, rd_data1;
  logic [2:0]  rd_addr1, wr_ptr1;

  int assertions = 0;
  int failures   = 0;

  logic [11:0] def_words [8] = '{12'hE01, 12'hE03, 12'hE07, 12'hE0F,
                                 12'hE1F, 12'hE3F, 12'hE7F, 12'hEFF};

  instr_mem_loader_p dut0 (
    .CLK(CLK), .reset_n(reset_n), .load_req(load_req0), .load_data(load_data0),
    .restore_req(restore_req0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .wr_ptr(wr_ptr0), .full(full0), .busy(busy0)
  );

  instr_mem_loader_p #(.DATA_W(12), .DEPTH(5), .WRAP(1)) dut1 (
    .CLK(CLK), .reset_n(reset_n), .load_req(load_req1), .load_data(load_data1),
    .restore_req(restore_req1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_ptr(wr_ptr1), .full(full1), .busy(busy1)
  );

  task automatic read0(input logic [2:0] a, output logic [11:0] d);
    rd_addr0 = a;
    @(negedge CLK);
    d = rd_data0;
  endtask

  task automatic read1(input logic [2:0] a, output logic [11:0] d);
    rd_addr1 = a;
    @(negedge CLK);
    d = rd_data1;
  endtask

  task automatic press0(input logic [11:0] d);
    load_data0 = d;
    load_req0  = 1'b1;
    @(negedge CLK);
    load_req0  = 1'b0;
    @(negedge CLK);
  endtask

  task automatic press1(input logic [11:0] d);
    load_data1 = d;
    load_req1  = 1'b1;
    @(negedge CLK);
    load_req1  = 1'b0;
    @(negedge CLK);
  endtask

  task automatic busy_len0(output int n);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy0 !== 1'b1) break;
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic restore0(output int n);
    restore_req0 = 1'b1;
    @(negedge CLK);
    restore_req0 = 1'b0;
    busy_len0(n);
  endtask

  task automatic test_reset;
    int          n;
    logic [11:0] d;
    reset_n = 1'b0;
    repeat (3) @(negedge CLK);
    assertions++;
    if (busy0 !== 1'b1 || wr_ptr0 !== 3'd0 || full0 !== 1'b0 || rd_data0 !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_state: busy=%b wr_ptr=%0d full=%b rd_data=%h expected 1 0 0 000",
               busy0, wr_ptr0, full0, rd_data0);
    end
    assertions++;
    if (busy1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_busy_wrap: got %b expected 1", busy1);
    end
    reset_n = 1'b1;
    busy_len0(n);
    assertions++;
    if (n != 8) begin
      failures++;
      $display("[TB] FAIL reset_busy_len: got %0d cycles expected 8", n);
    end
    for (int i = 0; i < 8; i++) begin
      read0(3'(i), d);
      assertions++;
      if (d !== def_words[i]) begin
        failures++;
        $display("[TB] FAIL default_word[%0d]: got %h expected %h", i, d, def_words[i]);
      end
    end
  endtask

  task automatic test_load;
    logic [11:0] d;
    press0(12'h123);
    press0(12'h456);
    assertions++;
    if (wr_ptr0 !== 3'd2) begin
      failures++;
      $display("[TB] FAIL load_wr_ptr: got %0d expected 2", wr_ptr0);
    end
    read0(3'd0, d);
    assertions++;
    if (d !== 12'h123) begin
      failures++;
      $display("[TB] FAIL load_mem0: got %h expected 123", d);
    end
    read0(3'd1, d);
    assertions++;
    if (d !== 12'h456) begin
      failures++;
      $display("[TB] FAIL load_mem1: got %h expected 456", d);
    end
    load_data0 = 12'h789;
    load_req0  = 1'b1;
    repeat (20) @(negedge CLK);
    load_req0 = 1'b0;
    @(negedge CLK);
    assertions++;
    if (wr_ptr0 !== 3'd3) begin
      failures++;
      $display("[TB] FAIL held_wr_ptr: got %0d expected 3", wr_ptr0);
    end
    read0(3'd2, d);
    assertions++;
    if (d !== 12'h789) begin
      failures++;
      $display("[TB] FAIL held_mem2: got %h expected 789", d);
    end
    read0(3'd3, d);
    assertions++;
    if (d !== 12'hE0F) begin
      failures++;
      $display("[TB] FAIL held_mem3: got %h expected E0F", d);
    end
  endtask

  task automatic test_full;
    int          n;
    logic [11:0] d;
    restore0(n);
    assertions++;
    if (n != 8 || wr_ptr0 !== 3'd0) begin
      failures++;
      $display("[TB] FAIL full_restore: busy=%0d wr_ptr=%0d expected 8 0", n, wr_ptr0);
    end
    for (int k = 0; k < 9; k++) begin
      press0(12'h100 + 12'(k));
      if (k == 6) begin
        assertions++;
        if (full0 !== 1'b0 || wr_ptr0 !== 3'd7) begin
          failures++;
          $display("[TB] FAIL full_press7: full=%b wr_ptr=%0d expected 0 7", full0, wr_ptr0);
        end
      end
      if (k >= 7) begin
        assertions++;
        if (full0 !== 1'b1 || wr_ptr0 !== 3'd7) begin
          failures++;
          $display("[TB] FAIL full_press%0d: full=%b wr_ptr=%0d expected 1 7", k + 1, full0, wr_ptr0);
        end
      end
    end
    read0(3'd7, d);
    assertions++;
    if (d !== 12'h107) begin
      failures++;
      $display("[TB] FAIL full_mem7: got %h expected 107", d);
    end
    read0(3'd0, d);
    assertions++;
    if (d !== 12'h100) begin
      failures++;
      $display("[TB] FAIL full_mem0: got %h expected 100", d);
    end
  endtask

  task automatic test_restore_collision;
    int          n;
    logic [11:0] d;
    restore0(n);
    assertions++;
    if (full0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL restore_clears_full: got %b expected 0", full0);
    end
    press0(12'h300);
    press0(12'h301);
    press0(12'h302);
    assertions++;
    if (wr_ptr0 !== 3'd3) begin
      failures++;
      $display("[TB] FAIL coll_setup_ptr: got %0d expected 3", wr_ptr0);
    end
    load_data0   = 12'h3FF;
    load_req0    = 1'b1;
    restore_req0 = 1'b1;
    @(negedge CLK);
    assertions++;
    if (wr_ptr0 !== 3'd0 || full0 !== 1'b0 || busy0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL coll_state: wr_ptr=%0d full=%b busy=%b expected 0 0 1", wr_ptr0, full0, busy0);
    end
    restore_req0 = 1'b0;
    load_req0    = 1'b0;
    busy_len0(n);
    assertions++;
    if (n != 8) begin
      failures++;
      $display("[TB] FAIL coll_busy_len: got %0d expected 8", n);
    end
    read0(3'd3, d);
    assertions++;
    if (d !== 12'hE0F) begin
      failures++;
      $display("[TB] FAIL coll_mem3: got %h expected E0F", d);
    end
    read0(3'd0, d);
    assertions++;
    if (d !== 12'hE01) begin
      failures++;
      $display("[TB] FAIL coll_mem0: got %h expected E01", d);
    end
  endtask

  task automatic test_reset_mid_restore;
    int          n;
    logic [11:0] d;
    restore_req0 = 1'b1;
    @(negedge CLK);
    restore_req0 = 1'b0;
    load_req0    = 1'b1;
    load_data0   = 12'hBAD;
    repeat (4) @(negedge CLK);
    assertions++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_busy: got %b expected 1", busy0);
    end
    reset_n = 1'b0;
    @(negedge CLK);
    assertions++;
    if (busy0 !== 1'b1 || wr_ptr0 !== 3'd0 || rd_data0 !== 12'h000) begin
      failures++;
      $display("[TB] FAIL mid_reset_state: busy=%b wr_ptr=%0d rd_data=%h expected 1 0 000",
               busy0, wr_ptr0, rd_data0);
    end
    @(negedge CLK);
    reset_n = 1'b1;
    busy_len0(n);
    assertions++;
    if (n != 8) begin
      failures++;
      $display("[TB] FAIL mid_busy_len: got %0d expected 8", n);
    end
    repeat (3) @(negedge CLK);
    assertions++;
    if (wr_ptr0 !== 3'd0) begin
      failures++;
      $display("[TB] FAIL mid_held_no_write: wr_ptr=%0d expected 0", wr_ptr0);
    end
    read0(3'd0, d);
    assertions++;
    if (d !== 12'hE01) begin
      failures++;
      $display("[TB] FAIL mid_mem0: got %h expected E01", d);
    end
    load_req0 = 1'b0;
    @(negedge CLK);
    press0(12'h5A5);
    read0(3'd0, d);
    assertions++;
    if (wr_ptr0 !== 3'd1 || d !== 12'h5A5) begin
      failures++;
      $display("[TB] FAIL mid_repress: wr_ptr=%0d mem0=%h expected 1 5A5", wr_ptr0, d);
    end
  endtask

  task automatic test_wrap;
    int          exp_ptr [6] = '{1, 2, 3, 4, 0, 1};
    logic [11:0] d;
    for (int c = 0; c < 20 && busy1 === 1'b1; c++) @(negedge CLK);
    read1(3'd4, d);
    assertions++;
    if (busy1 !== 1'b0 || d !== 12'hE1F) begin
      failures++;
      $display("[TB] FAIL wrap_default4: busy=%b mem4=%h expected 0 E1F", busy1, d);
    end
    for (int k = 0; k < 6; k++) begin
      press1(12'h600 + 12'(k));
      assertions++;
      if (wr_ptr1 !== 3'(exp_ptr[k]) || full1 !== 1'b0) begin
        failures++;
        $display("[TB] FAIL wrap_ptr%0d: wr_ptr=%0d full=%b expected %0d 0", k + 1, wr_ptr1, full1, exp_ptr[k]);
      end
    end
    read1(3'd0, d);
    assertions++;
    if (d !== 12'h605) begin
      failures++;
      $display("[TB] FAIL wrap_mem0: got %h expected 605", d);
    end
    read1(3'd4, d);
    assertions++;
    if (d !== 12'h604) begin
      failures++;
      $display("[TB] FAIL wrap_mem4: got %h expected 604", d);
    end
    read1(3'd6, d);
    assertions++;
    if (d !== 12'h000) begin
      failures++;
      $display("[TB] FAIL wrap_oob_read: got %h expected 000", d);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    load_req0    = 1'b0;
    restore_req0 = 1'b0;
    load_data0   = '0;
    rd_addr0     = '0;
    load_req1    = 1'b0;
    restore_req1 = 1'b0;
    load_data1   = '0;
    rd_addr1     = '0;
    @(negedge CLK);
    test_reset();
    test_load();
    test_full();
    test_restore_collision();
    test_reset_mid_restore();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "[TB] timeout");
  end

endmodule
